// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for uart_rx: line-idle arming, byte FIFO, error screening, irq.
// Define UART_RX_CTRL_ERR_TAG_EN to store errored frames with tag bits and expose m_err.
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int ARM_CYCLES     = 160,
    parameter int TIMEOUT_CYCLES = 1650,
    parameter int IRQ_THRESH     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ctrl_enable,
    input  logic                          ctrl_flush,
    input  logic                          err_clr,
    input  logic                          i_rx,
    output logic                          rx_en,
    input  logic                          rx_o_data_valid,
    input  logic [7:0]                    rx_o_data,
    input  logic                          rx_parity_err,
    input  logic                          rx_frame_err,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun_flag,
    output logic                          timeout_flag,
    output logic [7:0]                    err_cnt,
    output logic                          irq
`ifdef UART_RX_CTRL_ERR_TAG_EN
    ,
    output logic [1:0]                    m_err
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = $clog2(ARM_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef UART_RX_CTRL_ERR_TAG_EN
    localparam int EW = 10;
`else
    localparam int EW = 8;
`endif

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_ARM,
        ST_ACTIVE
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] arm_cnt_q, arm_cnt_d;
    logic          rx_en_q, rx_en_d;
    logic          valid_q, valid_d;

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          irq_q, irq_d;

    logic          push_ev;
    logic          err_ev;
    logic          wr_req;
    logic          full;
    logic          pop;
    logic          do_wr;
    logic          overrun_set;
    logic          timeout_set;
    logic [EW-1:0] entry;

    // Receiver enable sequencing
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        unique case (state_q)
            ST_DISABLED: begin
                arm_cnt_d = '0;
                if (ctrl_enable) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!ctrl_enable) begin
                    state_d   = ST_DISABLED;
                    arm_cnt_d = '0;
                end else if (!i_rx) begin
                    arm_cnt_d = '0;
                end else if (arm_cnt_q == AW'(ARM_CYCLES - 1)) begin
                    state_d   = ST_ACTIVE;
                    arm_cnt_d = '0;
                end else begin
                    arm_cnt_d = arm_cnt_q + AW'(1);
                end
            end
            ST_ACTIVE: begin
                if (!ctrl_enable) state_d = ST_DISABLED;
            end
            default: begin
                state_d   = ST_DISABLED;
                arm_cnt_d = '0;
            end
        endcase
        rx_en_d = (state_d == ST_ACTIVE);
    end

    assign valid_d = rx_o_data_valid;
    assign push_ev = rx_o_data_valid & ~valid_q & (state_q == ST_ACTIVE);
    assign err_ev  = push_ev & (rx_parity_err | rx_frame_err);

`ifdef UART_RX_CTRL_ERR_TAG_EN
    assign wr_req = push_ev;
    assign entry  = {rx_frame_err, rx_parity_err, rx_o_data};
`else
    assign wr_req = push_ev & ~err_ev;
    assign entry  = rx_o_data;
`endif

    assign m_valid = (count_q != '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = m_valid & m_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign do_wr       = ~ctrl_flush & wr_req & (~full | pop);
    assign overrun_set = ~ctrl_flush & wr_req & full & ~pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (ctrl_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) begin
                mem_d[wr_ptr_q] = entry;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_wr) - CW'(pop);
        end
    end

    // Counter parks one past the threshold so a cleared flag stays cleared
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        timeout_set = 1'b0;
        if (ctrl_flush | push_ev | pop | ~m_valid) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TW'(TIMEOUT_CYCLES)) begin
            tmo_cnt_d   = tmo_cnt_q + TW'(1);
            timeout_set = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
        end
    end

    always_comb begin
        overrun_d = overrun_set | (overrun_q & ~err_clr);
        timeout_d = timeout_set | (timeout_q & ~err_clr);
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = {7'd0, err_ev};
        end else if (err_ev && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        irq_d = (count_q >= CW'(IRQ_THRESH)) | overrun_q | timeout_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_DISABLED;
            arm_cnt_q <= '0;
            rx_en_q   <= 1'b0;
            valid_q   <= 1'b0;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            tmo_cnt_q <= '0;
            err_cnt_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            rx_en_q   <= rx_en_d;
            valid_q   <= valid_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            tmo_cnt_q <= tmo_cnt_d;
            err_cnt_q <= err_cnt_d;
            irq_q     <= irq_d;
        end
    end

    assign rx_en        = rx_en_q;
    assign m_data       = mem_q[rd_ptr_q][7:0];
    assign fifo_count   = count_q;
    assign overrun_flag = overrun_q;
    assign timeout_flag = timeout_q;
    assign err_cnt      = err_cnt_q;
    assign irq          = irq_q;

`ifdef UART_RX_CTRL_ERR_TAG_EN
    assign m_err = m_valid ? mem_q[rd_ptr_q][9:8] : 2'b00;
`endif

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller for the UART RX datapath (uart_rx).
- Sequences the receiver enable: arms uart_rx only after the line has been idle-high long enough, so it never starts mid-frame.
- Captures each completed byte into a small FIFO and screens parity/stop errors.
- Presents bytes to the consumer with a valid/ready handshake, plus status and interrupt outputs.

Parameters:
FIFO_DEPTH, 8, byte FIFO entries; power of 2, minimum 2.
ARM_CYCLES, 160, consecutive clk cycles of i_rx high required before rx_en asserts.
TIMEOUT_CYCLES, 1650, idle clk cycles with a non-empty FIFO before timeout_flag sets.
IRQ_THRESH, 4, FIFO count at or above which irq asserts; range 1..FIFO_DEPTH.

Ports:
clk  in  1  system clock, shared with uart_rx (rx_clk).
rst_n  in  1  synchronous, active-low reset.
ctrl_enable  in  1  software receive enable, level.
ctrl_flush  in  1  one-cycle pulse; empties the FIFO.
err_clr  in  1  one-cycle pulse; clears sticky flags and err_cnt.
i_rx  in  1  serial line monitor, same net as uart_rx i_rx.
rx_en  out  1  drives uart_rx rx_en.
rx_o_data_valid  in  1  from uart_rx; a byte completes on its rising edge.
rx_o_data  in  8  from uart_rx.
rx_parity_err  in  1  from uart_rx; qualified with rx_o_data_valid.
rx_frame_err  in  1  from uart_rx, bad stop bit; qualified with rx_o_data_valid.
m_data  out  8  head-of-FIFO byte.
m_valid  out  1  FIFO non-empty.
m_ready  in  1  consumer accepts; pop when m_valid && m_ready.
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
overrun_flag  out  1  sticky; a byte was dropped because the FIFO was full.
timeout_flag  out  1  sticky; FIFO data sat idle for TIMEOUT_CYCLES.
err_cnt  out  8  count of errored frames, saturates at 255.
irq  out  1  (fifo_count >= IRQ_THRESH) | overrun_flag | timeout_flag.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State DISABLED; rx_en=0.
  - FIFO empty, so m_valid=0 and fifo_count=0; m_data=0.
  - All flags 0; err_cnt=0; irq=0; ARM counter and timeout counter 0.
- Reset mid-frame aborts everything; a partial frame is lost.
- FSM:
  - DISABLED: rx_en=0. Go to ARM when ctrl_enable=1.
  - ARM: rx_en=0. The ARM counter increments while i_rx=1 and clears to 0 when i_rx=0. When the counter reaches ARM_CYCLES-1 with i_rx=1, go to ACTIVE. ctrl_enable=0 returns to DISABLED.
  - ACTIVE: rx_en=1, registered, so it is high from the first ACTIVE cycle. ctrl_enable=0 returns to DISABLED and rx_en falls on the next cycle. A valid edge in that same cycle is still captured.
- Capture:
  - valid_q registers rx_o_data_valid. Push event = rx_o_data_valid & ~valid_q & (state==ACTIVE).
  - A held-high valid therefore pushes exactly once.
  - Error frame = push event with rx_parity_err | rx_frame_err. It increments err_cnt (saturating) and is not written to the FIFO.
- Latency: a push event in cycle N writes the FIFO at the end of cycle N; m_valid=1 and m_data=byte in cycle N+1.
- FIFO:
  - m_data = mem[rd_ptr] (fall-through).
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- FIFO boundary cases:
  - Full, push without pop: byte dropped, overrun_flag=1, count unchanged.
  - Full, push with pop in the same cycle: both occur, count stays FIFO_DEPTH, no overrun.
  - Empty, pop attempt: impossible because m_valid=0; no pointer change.
  - ctrl_flush: rd_ptr=wr_ptr=0 and count=0 next cycle. A push in the same cycle is discarded without setting overrun. Flags are untouched.
- Timeout:
  - The counter runs while count>0 and no push or pop occurs that cycle. Any push, pop or flush resets it to 0.
  - At TIMEOUT_CYCLES-1 it sets timeout_flag and holds.
  - It does not run when the FIFO is empty.
- err_clr clears overrun_flag, timeout_flag and err_cnt. A set condition in the same cycle wins: the flag ends at 1 and err_cnt ends at 1.
- Interrupt: irq is a registered OR of the terms above, so it lags its cause by 1 cycle.

Optional Feature:
Macro UART_RX_CTRL_ERR_TAG_EN.
- Defined:
  - FIFO entries are 10 bits: {frame_err, parity_err, data}.
  - Errored frames are stored, not dropped, and still increment err_cnt.
  - An extra output port m_err [1:0] = {frame_err, parity_err} of the head entry; 0 at reset or when empty.
- Undefined: behaviour as above; there is no m_err port.

Test Plan:
1. Enable with i_rx low for 300 cycles, then high -> rx_en rises exactly ARM_CYCLES (160) cycles after i_rx goes high, never earlier.
2. ACTIVE; valid edges with 0xCE then 0xAA, no errors, m_ready=1 -> m_data 0xCE then 0xAA, each m_valid 1 cycle after its edge; fifo_count ends at 0; err_cnt=0.
3. m_ready=0; push 9 bytes 0x00..0x08 -> fifo_count=8, overrun_flag=1, irq=1. Drain -> bytes 0x00..0x07 in order.
4. 0xAA with rx_frame_err=1 -> err_cnt=1 and FIFO empty. With UART_RX_CTRL_ERR_TAG_EN defined: m_data=0xAA, m_err=2'b10.
5. One byte pushed, m_ready=0 -> timeout_flag=1 after 1650 idle cycles. err_clr pulse -> flag 0. Same test with a push at cycle 1000 -> flag not set at 1650.
6. FIFO at 8 with a push plus pop in the same cycle -> count stays 8, no overrun. ctrl_flush together with a push -> count=0, overrun_flag=0.
